chebyshev_sequencer: RTL and testbench

- Iteration controller for the Chebyshev datapath.
- Sequences the recurrence T_k over orders k = 0..ORDER. For each order it issues N_ELEM element indices to the datapath under a valid/ready handshake.
- After each order it waits DRAIN_CYCLES so the datapath pipeline empties before T_{k+1}, which depends on T_k, is issued.
- Built from the team's nested up-counter pattern: an element counter inside an order counter, plus a drain counter.

---
 rtl/chebyshev_sequencer.sv | 70 +++++++
 tb/tb_chebyshev_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chebyshev_sequencer.sv
// chebyshev_sequencer: issues element/order indices for the Chebyshev recurrence, draining between orders.
module chebyshev_sequencer #(
  parameter int IDX_WIDTH    = 4,
  parameter int N_ELEM       = 4,
  parameter int ORD_WIDTH    = 2,
  parameter int ORDER        = 3,
  parameter int DRAIN_WIDTH  = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 issue_ready,
  output logic                 issue_valid,
  output logic [IDX_WIDTH-1:0] elem_idx,
  output logic [ORD_WIDTH-1:0] iter_idx,
  output logic                 first_elem,
  output logic                 last_elem,
  output logic                 last_iter,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [IDX_WIDTH-1:0]   ELEM_LAST  = IDX_WIDTH'(N_ELEM - 1);
  localparam logic [ORD_WIDTH-1:0]   ITER_LAST  = ORD_WIDTH'(ORDER);
  localparam logic [DRAIN_WIDTH-1:0] DRAIN_LOAD = DRAIN_WIDTH'(DRAIN_CYCLES - 1);
  state_t                 state, state_nxt;
  logic [DRAIN_WIDTH-1:0] drain_cnt;
  logic                   at_last_elem, at_last_iter;
  assign at_last_elem = elem_idx == ELEM_LAST;
  assign at_last_iter = iter_idx == ITER_LAST;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  // abort beats start in IDLE and beats every transfer/drain decision elsewhere
  always_comb
    state_nxt = abort ? IDLE :
                state == IDLE  ? (start ? ISSUE : IDLE) :
                state == ISSUE ? (issue_ready && at_last_elem ? DRAIN : ISSUE) :
                state == DRAIN ? (drain_cnt != '0 ? DRAIN : at_last_iter ? DONE : ISSUE) :
                IDLE;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      elem_idx  <= '0;
      iter_idx  <= '0;
      drain_cnt <= '0;
    end else if (abort || state == IDLE || state == DONE) begin
      elem_idx  <= '0;
      iter_idx  <= '0;
      drain_cnt <= '0;
    end else if (state == ISSUE) begin
      if (issue_ready) begin
        elem_idx <= at_last_elem ? '0 : elem_idx + 1'b1;
        if (at_last_elem) drain_cnt <= DRAIN_LOAD;
      end
    end else if (drain_cnt != '0) begin
      drain_cnt <= drain_cnt - 1'b1;
    end else if (!at_last_iter) begin
      iter_idx <= iter_idx + 1'b1;
    end
  always_comb begin
    issue_valid = state == ISSUE;
    busy        = state != IDLE;
    done        = state == DONE;
    first_elem  = issue_valid && elem_idx == '0;
    last_elem   = issue_valid && at_last_elem;
    last_iter   = busy && at_last_iter;
  end
endmodule

// File: tb/tb_chebyshev_sequencer.sv
// tb_chebyshev_sequencer: randomized-handshake bench against a queue-based model of the issue schedule.
module tb_chebyshev_sequencer;
  localparam int IW = 4, N = 4, OW = 2, ORD = 3, DW = 2, D = 2;
  logic clock = 0, resetn = 0, start = 0, abort = 0, issue_ready = 1;
  logic issue_valid, first_elem, last_elem, last_iter, busy, done;
  logic [IW-1:0] elem_idx;
  logic [OW-1:0] iter_idx;
  logic start_s = 0, abort_s = 0, ready_s = 1;
  logic issue_valid_s, first_elem_s, last_elem_s, last_iter_s, busy_s, done_s;
  logic [IW-1:0] elem_idx_s;
  logic [OW-1:0] iter_idx_s;
  logic [11:0] obs, obs_s;
  int cyc = 0, n_cmp = 0, n_fail = 0;

  chebyshev_sequencer #(.IDX_WIDTH(IW), .N_ELEM(N), .ORD_WIDTH(OW), .ORDER(ORD),
                        .DRAIN_WIDTH(DW), .DRAIN_CYCLES(D)) dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .elem_idx(elem_idx), .iter_idx(iter_idx), .first_elem(first_elem),
    .last_elem(last_elem), .last_iter(last_iter), .busy(busy), .done(done));

  chebyshev_sequencer #(.IDX_WIDTH(IW), .N_ELEM(1), .ORD_WIDTH(OW), .ORDER(0),
                        .DRAIN_WIDTH(DW), .DRAIN_CYCLES(1)) dut_s (
    .clock(clock), .resetn(resetn), .start(start_s), .abort(abort_s), .issue_ready(ready_s),
    .issue_valid(issue_valid_s), .elem_idx(elem_idx_s), .iter_idx(iter_idx_s),
    .first_elem(first_elem_s), .last_elem(last_elem_s), .last_iter(last_iter_s),
    .busy(busy_s), .done(done_s));

  assign obs   = {issue_valid, busy, done, first_elem, last_elem, last_iter, iter_idx, elem_idx};
  assign obs_s = {issue_valid_s, busy_s, done_s, first_elem_s, last_elem_s, last_iter_s, iter_idx_s, elem_idx_s};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // mode 0: ready high, 1: random ready, 2: 3-cycle stall at (1,2), 3: start left high
  task automatic run_seq(input int mode, output int s_cyc, output int d_cyc);
    int q_k[$], q_i[$];
    int quiet, stalls, stall_left, cur_k;
    bit ev, ed, ready, fin;
    logic [11:0] exp;
    for (int k = 0; k <= ORD; k++)
      for (int i = 0; i < N; i++) begin
        q_k.push_back(k);
        q_i.push_back(i);
      end
    quiet = 0; stalls = 0; stall_left = 3; cur_k = 0; fin = 0; d_cyc = -1;
    start = 1;
    @(negedge clock);
    s_cyc = cyc;
    if (mode != 3) start = 0;
    for (int c = 1; c <= 400 && !fin; c++) begin
      ev = q_k.size() > 0 && quiet == 0;
      ed = q_k.size() == 0 && quiet == 0;
      if (ev) cur_k = q_k[0];
      exp = {ev, 1'b1, ed, ev ? q_i[0] == 0 : 1'b0, ev ? q_i[0] == N - 1 : 1'b0,
             cur_k == ORD, OW'(cur_k), ev ? IW'(q_i[0]) : IW'(0)};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL run_seq mode=%0d cycle=%0d got=%b expected=%b", mode, c, obs, exp);
      end
      ready = 1;
      if (mode == 1) ready = $urandom_range(0, 3) != 0;
      if (mode == 2 && ev && cur_k == 1 && q_i[0] == 2 && stall_left > 0) begin
        ready = 0;
        stall_left--;
      end
      issue_ready = ready;
      if (ev) begin
        if (ready) begin
          if (q_i[0] == N - 1) quiet = D;
          void'(q_k.pop_front());
          void'(q_i.pop_front());
        end else stalls++;
      end else if (quiet > 0) quiet--;
      else begin
        fin = 1;
        d_cyc = c;
      end
      @(negedge clock);
    end
    n_cmp++;
    if (d_cyc != (ORD + 1) * (N + D) + 1 + stalls) begin
      n_fail++;
      $display("FAIL done_cycle mode=%0d got=%0d expected=%0d", mode, d_cyc, (ORD + 1) * (N + D) + 1 + stalls);
    end
    n_cmp++;
    if (obs !== 12'b0) begin
      n_fail++;
      $display("FAIL idle_after_done mode=%0d got=%b expected=%b", mode, obs, 12'b0);
    end
    issue_ready = 1;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if (obs !== 12'b0 || obs_s !== 12'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%b/%b expected=0/0", obs, obs_s);
    end
    @(negedge clock);
    resetn = 1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic;
    int s, d;
    run_seq(0, s, d);
  endtask

  task automatic test_stall;
    int s, d;
    run_seq(2, s, d);
    n_cmp++;
    if (d != 28) begin
      n_fail++;
      $display("FAIL stall_done got=%0d expected=28", d);
    end
  endtask

  task automatic test_random_ready;
    int s, d;
    repeat (3) run_seq(1, s, d);
  endtask

  task automatic test_back_to_back;
    int s1, d1, s2, d2;
    run_seq(3, s1, d1);
    run_seq(3, s2, d2);
    start = 0;
    n_cmp++;
    if (s2 - s1 + d2 != 51) begin
      n_fail++;
      $display("FAIL back_to_back_done got=%0d expected=51", s2 - s1 + d2);
    end
    @(negedge clock);
  endtask

  task automatic test_abort;
    int s, d;
    bit seen;
    start = 1; abort = 1;
    @(negedge clock);
    start = 0; abort = 0;
    n_cmp++;
    if (obs !== 12'b0) begin
      n_fail++;
      $display("FAIL abort_beats_start got=%b expected=%b", obs, 12'b0);
    end
    start = 1;
    @(negedge clock);
    start = 0;
    repeat (16) @(negedge clock);
    n_cmp++;
    if (obs !== {6'b010000, 2'd2, 4'd0}) begin
      n_fail++;
      $display("FAIL drain_k2 got=%b expected=%b", obs, {6'b010000, 2'd2, 4'd0});
    end
    abort = 1;
    @(negedge clock);
    abort = 0;
    n_cmp++;
    if (obs !== 12'b0) begin
      n_fail++;
      $display("FAIL after_abort got=%b expected=%b", obs, 12'b0);
    end
    seen = 0;
    repeat (30) begin
      @(negedge clock);
      seen |= done | busy;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done got=%b expected=0", seen);
    end
    run_seq(0, s, d);
  endtask

  task automatic test_async_reset;
    bit seen;
    start = 1;
    @(negedge clock);
    start = 0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2;
    n_cmp++;
    if (issue_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid got=%b expected=1", issue_valid);
    end
    resetn = 0;
    #1;
    n_cmp++;
    if (obs !== 12'b0) begin
      n_fail++;
      $display("FAIL async_reset got=%b expected=%b", obs, 12'b0);
    end
    @(negedge clock);
    resetn = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      seen |= busy | issue_valid;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got=%b expected=0", seen);
    end
  endtask

  task automatic test_min_params;
    logic [11:0] exp [4];
    exp[0] = {6'b110111, 2'd0, 4'd0};
    exp[1] = {6'b010001, 2'd0, 4'd0};
    exp[2] = {6'b011001, 2'd0, 4'd0};
    exp[3] = 12'b0;
    start_s = 1;
    @(negedge clock);
    start_s = 0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (obs_s !== exp[c]) begin
        n_fail++;
        $display("FAIL min_params cycle=%0d got=%b expected=%b", c + 1, obs_s, exp[c]);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_random_ready;
    test_back_to_back;
    test_abort;
    test_async_reset;
    test_min_params;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
